// File: rtl/wb_master_pkg.sv
// Shared types and helpers for the single-transaction Wishbone master bridge.
package wb_master_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // A zero timeout still needs a 1-bit counter so the port widths stay legal.
    function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
        return (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/wb_master_bridge_timeout.sv
// Saturating watchdog counter; expired flags the last allowed ACTIVE cycle.
module wb_timeout_counter
    import wb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CW             = cnt_width(TIMEOUT_CYCLES)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned     LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CW-1:0]   LAST   = CW'(LAST_I);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            cnt <= '0;
        end else if (enable && (cnt != '1)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (cnt == LAST);

endmodule

// File: rtl/wb_master_bridge.sv
// Core request/done handshake to a Wishbone classic cycle, with a bus-timeout watchdog.
module wb_master_bridge
    import wb_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    busy_o,
    output logic [ADDR_WIDTH-1:0]   ADR_O,
    output logic [DATA_WIDTH-1:0]   DAT_O,
    input  logic [DATA_WIDTH-1:0]   DAT_I,
    output logic                    WE_O,
    output logic [DATA_WIDTH/8-1:0] SEL_O,
    output logic                    STB_O,
    output logic                    CYC_O,
    input  logic                    ACK_I
);

    state_t state;
    logic   tmo_clear;
    logic   tmo_enable;
    logic   tmo_expired;

    assign tmo_clear  = (state == IDLE) && req_i;
    assign tmo_enable = (state == ACTIVE) && !ACK_I && !tmo_expired;

    wb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            STB_O   <= 1'b0;
            CYC_O   <= 1'b0;
            WE_O    <= 1'b0;
            ADR_O   <= '0;
            DAT_O   <= '0;
            SEL_O   <= '0;
            rdata_o <= '0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_i) begin
                        ADR_O <= addr_i;
                        DAT_O <= wdata_i;
                        SEL_O <= sel_i;
                        WE_O  <= we_i;
                        STB_O <= 1'b1;
                        CYC_O <= 1'b1;
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // ACK takes priority over a timeout landing on the same cycle.
                    if (ACK_I) begin
                        if (!WE_O) begin
                            rdata_o <= DAT_I;
                        end
                        STB_O  <= 1'b0;
                        CYC_O  <= 1'b0;
                        WE_O   <= 1'b0;
                        done_o <= 1'b1;
                        state  <= RELEASE;
                    end else if (tmo_expired) begin
                        STB_O <= 1'b0;
                        CYC_O <= 1'b0;
                        err_o <= 1'b1;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!ACK_I) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Scoreboard bench for wb_master_bridge: stimulus queues expected completions, a monitor checks them.
module tb_wb_master_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  sel_i;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        err_o;
    logic        busy_o;
    logic [31:0] ADR_O;
    logic [31:0] DAT_O;
    logic [31:0] DAT_I;
    logic        WE_O;
    logic [3:0]  SEL_O;
    logic        STB_O;
    logic        CYC_O;
    logic        ACK_I;

    wb_master_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .sel_i   (sel_i),
        .rdata_o (rdata_o),
        .done_o  (done_o),
        .err_o   (err_o),
        .busy_o  (busy_o),
        .ADR_O   (ADR_O),
        .DAT_O   (DAT_O),
        .DAT_I   (DAT_I),
        .WE_O    (WE_O),
        .SEL_O   (SEL_O),
        .STB_O   (STB_O),
        .CYC_O   (CYC_O),
        .ACK_I   (ACK_I)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_err;
        logic [31:0] rdata;
        int unsigned stb;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        bit          we;
    } exp_t;

    exp_t        sb[$];
    int unsigned checks      = 0;
    int unsigned errors      = 0;
    int unsigned starts_exp  = 0;
    int unsigned starts_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_txn(input bit is_err, input logic [31:0] rdata, input int unsigned stb,
                              input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                              input bit we);
        exp_t e;
        e.is_err = is_err; e.rdata = rdata; e.stb = stb;
        e.adr = adr; e.dat = dat; e.sel = sel; e.we = we;
        sb.push_back(e);
    endtask

    task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = d; sel_i = s;
        starts_exp++;
        tick();
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; sel_i = '0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_stb"},   32'(STB_O),  32'd0);
        chk({tag, "_cyc"},   32'(CYC_O),  32'd0);
        chk({tag, "_we"},    32'(WE_O),   32'd0);
        chk({tag, "_busy"},  32'(busy_o), 32'd0);
        chk({tag, "_done"},  32'(done_o), 32'd0);
        chk({tag, "_err"},   32'(err_o),  32'd0);
        chk({tag, "_adr"},   ADR_O,       32'd0);
        chk({tag, "_dat"},   DAT_O,       32'd0);
        chk({tag, "_sel"},   32'(SEL_O),  32'd0);
        chk({tag, "_rdata"}, rdata_o,     32'd0);
    endtask

    // Monitor: tracks each strobe window and checks completions against the scoreboard.
    logic        prev_stb = 1'b0;
    int unsigned stb_run  = 0;
    bit          unstable = 1'b0;
    logic [31:0] cap_adr, cap_dat;
    logic [3:0]  cap_sel;
    logic        cap_we;

    always @(negedge clk_i) begin
        if (rst_i) begin
            stb_run  = 0;
            unstable = 1'b0;
        end else begin
            if (STB_O && !prev_stb) begin
                starts_seen++;
                stb_run  = 0;
                unstable = 1'b0;
                cap_adr  = ADR_O; cap_dat = DAT_O; cap_sel = SEL_O; cap_we = WE_O;
            end
            if (STB_O) begin
                stb_run++;
                if (ADR_O !== cap_adr || DAT_O !== cap_dat || SEL_O !== cap_sel ||
                    WE_O !== cap_we || CYC_O !== 1'b1)
                    unstable = 1'b1;
            end
            if (done_o || err_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", 32'(done_o | err_o), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("err_pulse",    32'(err_o),   32'(e.is_err));
                    chk("done_pulse",   32'(done_o),  32'(!e.is_err));
                    chk("rdata",        rdata_o,      e.rdata);
                    chk("stb_cycles",   32'(stb_run), 32'(e.stb));
                    chk("adr",          cap_adr,      e.adr);
                    chk("we",           32'(cap_we),  32'(e.we));
                    chk("sel",          32'(cap_sel), 32'(e.sel));
                    if (e.we) chk("dat", cap_dat, e.dat);
                    chk("wb_stable",    32'(unstable), 32'd0);
                    chk("latency",      32'(prev_stb), 32'd1);
                    chk("busy_at_done", 32'(busy_o),  32'd1);
                end
            end
        end
        prev_stb = STB_O;
    end

    initial begin
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        sel_i = '0; DAT_I = '0; ACK_I = 1'b0;
        tick(); tick();
        chk_reset_values("reset");
        rst_i = 1'b0;
        tick();

        // Read, ACK on the 4th strobe cycle
        expect_txn(1'b0, 32'hDEAD_BEEF, 4, 32'h10, 32'h0, 4'hF, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 4'hF);
        repeat (3) tick();
        ACK_I = 1'b1; DAT_I = 32'hDEAD_BEEF;
        tick();
        ACK_I = 1'b0; DAT_I = '0;
        chk("busy_release", 32'(busy_o), 32'd1);
        tick();
        chk("busy_idle", 32'(busy_o), 32'd0);
        tick();

        // Write, ACK on the 2nd strobe cycle; read data must not be captured
        expect_txn(1'b0, 32'hDEAD_BEEF, 2, 32'h20, 32'h1234_5678, 4'b0011, 1'b1);
        issue(1'b1, 32'h20, 32'h1234_5678, 4'b0011);
        tick();
        ACK_I = 1'b1; DAT_I = 32'hFFFF_FFFF;
        tick();
        ACK_I = 1'b0; DAT_I = '0;
        tick(); tick();

        // Timeout: no ACK for 8 strobe cycles
        expect_txn(1'b1, 32'hDEAD_BEEF, 8, 32'h30, 32'h0, 4'hF, 1'b0);
        issue(1'b0, 32'h30, 32'h0, 4'hF);
        repeat (11) tick();

        // Read after timeout, immediate ACK
        expect_txn(1'b0, 32'hCAFE_F00D, 1, 32'h40, 32'h0, 4'hF, 1'b0);
        issue(1'b0, 32'h40, 32'h0, 4'hF);
        ACK_I = 1'b1; DAT_I = 32'hCAFE_F00D;
        tick();
        ACK_I = 1'b0; DAT_I = '0;
        tick(); tick();

        // Stale ACK held 4 cycles; req_i during RELEASE must be ignored
        expect_txn(1'b0, 32'h0BAD_F00D, 1, 32'h50, 32'h0, 4'hF, 1'b0);
        issue(1'b0, 32'h50, 32'h0, 4'hF);
        ACK_I = 1'b1; DAT_I = 32'h0BAD_F00D;
        tick();
        req_i = 1'b1; addr_i = 32'hA0;
        tick(); tick();
        req_i = 1'b0; addr_i = '0;
        tick();
        ACK_I = 1'b0; DAT_I = '0;
        chk("busy_stale_ack", 32'(busy_o), 32'd1);
        tick(); tick(); tick();

        // req_i pulse during ACTIVE must not start a second cycle
        expect_txn(1'b0, 32'h0BAD_F00D, 3, 32'h60, 32'hA5A5_A5A5, 4'b1100, 1'b1);
        issue(1'b1, 32'h60, 32'hA5A5_A5A5, 4'b1100);
        tick();
        req_i = 1'b1; addr_i = 32'hB0;
        tick();
        req_i = 1'b0; addr_i = '0;
        ACK_I = 1'b1;
        tick();
        ACK_I = 1'b0;
        tick(); tick(); tick();

        // ACK on the exact timeout cycle: done wins
        expect_txn(1'b0, 32'h55AA_55AA, 8, 32'h70, 32'h0, 4'hF, 1'b0);
        issue(1'b0, 32'h70, 32'h0, 4'hF);
        repeat (7) tick();
        ACK_I = 1'b1; DAT_I = 32'h55AA_55AA;
        tick();
        ACK_I = 1'b0; DAT_I = '0;
        tick(); tick();

        // Reset mid-ACTIVE: no completion, everything back to reset values
        issue(1'b1, 32'h80, 32'hFFFF_0000, 4'hF);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk_reset_values("midreset");
        tick(); tick();

        // Read after reset
        expect_txn(1'b0, 32'h1357_9BDF, 2, 32'h90, 32'h0, 4'h5, 1'b0);
        issue(1'b0, 32'h90, 32'h0, 4'h5);
        tick();
        ACK_I = 1'b1; DAT_I = 32'h1357_9BDF;
        tick();
        ACK_I = 1'b0; DAT_I = '0;
        repeat (4) tick();

        chk("pending_completions", 32'(sb.size()), 32'd0);
        chk("cycles_started", 32'(starts_seen), 32'(starts_exp));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
- Single-transaction Wishbone master, directly upstream of the WB slave: converts a simple core-side request/done handshake into a WB classic cycle (CYC/STB/WE/SEL/ADR/DAT) and returns read data.
- Adds a bus-timeout watchdog, so an unresponsive slave ends the cycle with an error pulse and the core never stalls indefinitely.

Parameters:
- ADDR_WIDTH, 32, address width of core and WB sides
- DATA_WIDTH, 32, data width; SEL width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 255, number of ACTIVE cycles without ACK_I before abort; 0 disables the timeout

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; synchronous, active-high
- req_i  in  1  core request; sampled only in IDLE
- we_i  in  1  1=write, 0=read; sampled with req_i
- addr_i  in  ADDR_WIDTH  request address
- wdata_i  in  DATA_WIDTH  write data
- sel_i  in  DATA_WIDTH/8  byte selects
- rdata_o  out  DATA_WIDTH  read data; updated on read completion and held until the next read completion
- done_o  out  1  1-cycle pulse on successful completion
- err_o  out  1  1-cycle pulse on timeout
- busy_o  out  1  high whenever state != IDLE
- ADR_O  out  ADDR_WIDTH  WB address
- DAT_O  out  DATA_WIDTH  WB write data
- DAT_I  in  DATA_WIDTH  WB read data
- WE_O  out  1  WB write enable
- SEL_O  out  DATA_WIDTH/8  WB byte selects
- STB_O  out  1  WB strobe
- CYC_O  out  1  WB cycle
- ACK_I  in  1  WB acknowledge

Behaviour:
- Reset (synchronous): state=IDLE; STB_O=CYC_O=WE_O=0; ADR_O, DAT_O, SEL_O, rdata_o = 0; done_o=err_o=0; timeout counter=0. Reset mid-transaction drops CYC/STB at the next edge with no done/err pulse.
- All outputs except busy_o are registered. busy_o is decoded from state.
- States: IDLE, ACTIVE, RELEASE.
- IDLE:
  - When req_i=1, latch addr/wdata/sel/we into ADR_O/DAT_O/SEL_O/WE_O.
  - Set STB_O=CYC_O=1, clear the counter, go to ACTIVE. STB rises the cycle after req_i.
- ACTIVE: STB_O/CYC_O held high and the WB outputs are stable.
  - If ACK_I=1:
    - capture DAT_I into rdata_o (reads only);
    - drop STB/CYC and WE_O;
    - pulse done_o on the next cycle;
    - go to RELEASE.
  - Otherwise, if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1:
    - drop STB/CYC;
    - pulse err_o;
    - leave rdata_o unchanged;
    - go to RELEASE.
  - Otherwise increment the counter. The counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates, never wraps.
  - ACK and timeout in the same cycle: ACK wins, so done_o pulses and err_o does not.
- RELEASE:
  - STB/CYC low for at least one cycle, which lets the slave return to its idle state.
  - Stay while ACK_I=1, so a stale ACK is not consumed by the next cycle; go to IDLE when ACK_I=0.
- Request acceptance:
  - req_i while busy_o=1 is ignored, not queued.
  - The core re-asserts req_i after done_o/err_o.
  - Minimum request-to-request spacing is 3 cycles: IDLE, ACTIVE with immediate ACK, RELEASE.
- Latency: req_i at cycle t gives STB at t+1. An ACK seen at cycle n gives done_o and valid rdata_o at n+1.
- ACK_I outside ACTIVE is ignored. DAT_I is sampled only on ACK in ACTIVE for reads.

Decomposition:
- Package wb_master_pkg:
  - state_t enum (logic [1:0]: IDLE=0, ACTIVE=1, RELEASE=2);
  - a localparam function for the counter width.
- Optional sub-module wb_timeout_counter (clear, enable, expired output). Otherwise the block is a single module.

Test Plan:
- Read: req_i=1, we_i=0, addr_i=0x0000_0010; slave ACKs 3 cycles after STB with DAT_I=0xDEAD_BEEF -> STB/CYC high for exactly 4 cycles, WE_O=0, rdata_o=0xDEAD_BEEF and done_o pulse 1 cycle after ACK, busy_o low 2 cycles after ACK.
- Write: we_i=1, addr_i=0x20, wdata_i=0x1234_5678, sel_i=4'b0011; ACK after 1 cycle -> ADR_O/DAT_O/SEL_O/WE_O stable through ACTIVE, done_o pulses once, rdata_o unchanged.
- Timeout: TIMEOUT_CYCLES=8, no ACK -> STB high exactly 8 cycles, err_o single pulse, done_o never, return to IDLE; a later read still completes normally.
- Stale ACK: slave holds ACK_I high 4 cycles -> master stays in RELEASE until ACK_I low; a req_i asserted meanwhile is ignored and no second cycle starts.
- Busy drop and ACK/timeout collision: req_i pulses during ACTIVE -> no extra transaction. ACK on the exact timeout cycle -> done_o=1, err_o=0.
- Reset mid-ACTIVE: assert rst_i one cycle -> STB/CYC/done_o/err_o 0 at the next edge, busy_o=0, all outputs at reset values.
